// File: rtl/snn_inference_sequencer.sv
// Sequencer for one CartPole SNN inference: clear, step hidden layers per timestep,
// run the Q accumulator, pick the argmax action and hand it to the host.
module snn_inference_sequencer #(
    parameter int NUM_TIMESTEPS  = 30,
    parameter int NUM_ACTIONS    = 2,
    parameter int DATA_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 1023,
    parameter int CYC_WIDTH      = 16,
    localparam int TS_W   = (NUM_TIMESTEPS > 1) ? $clog2(NUM_TIMESTEPS) : 1,
    localparam int ACT_W  = (NUM_ACTIONS > 1) ? $clog2(NUM_ACTIONS) : 1,
    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   obs_valid,
    output logic                                   obs_ready,
    output logic                                   net_clear,
    output logic                                   layer_step,
    input  logic                                   layer_done,
    output logic [TS_W-1:0]                        timestep,
    output logic                                   buf_wr_en,
    output logic                                   qacc_start,
    input  logic                                   qacc_done,
    input  logic [NUM_ACTIONS-1:0][DATA_WIDTH-1:0] q_values,
    output logic                                   result_valid,
    input  logic                                   result_ready,
    output logic [ACT_W-1:0]                       action,
    output logic [DATA_WIDTH-1:0]                  q_best,
    output logic [CYC_WIDTH-1:0]                   cycles,
    output logic                                   busy,
    output logic                                   error,
    output logic [3:0]                             state_dbg
);

    // Host handshakes: a transfer happens on a clock edge where valid and ready are
    // both high; obs_ready is high only in IDLE and result_valid only in OUTPUT.
    typedef enum logic [3:0] {
        S_IDLE       = 4'd0,
        S_CLEAR      = 4'd1,
        S_STEP       = 4'd2,
        S_WAIT_LAYER = 4'd3,
        S_WRITE      = 4'd4,
        S_Q_START    = 4'd5,
        S_Q_WAIT     = 4'd6,
        S_ARGMAX     = 4'd7,
        S_OUTPUT     = 4'd8
    } state_e;

    localparam logic [TS_W-1:0]   LAST_TS   = TS_W'(NUM_TIMESTEPS - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

    state_e                  state_q, state_d;
    logic [TS_W-1:0]         timestep_q, timestep_d;
    logic [WAIT_W-1:0]       wait_cnt_q, wait_cnt_d;
    logic [CYC_WIDTH-1:0]    cycles_q, cycles_d;
    logic [ACT_W-1:0]        action_q, action_d;
    logic [DATA_WIDTH-1:0]   q_best_q, q_best_d;
    logic                    error_q, error_d;
    logic                    done_prev_q, done_prev_d;

    logic                    accept;
    logic                    done_rise;
    logic                    wait_expired;
    logic [ACT_W-1:0]        best_idx;
    logic [DATA_WIDTH-1:0]   best_val;

    assign accept       = (state_q == S_IDLE) && obs_valid;
    // A done level left high by the previous run must not count as completion.
    assign done_rise    = qacc_done && !done_prev_q;
    assign wait_expired = (wait_cnt_q == WAIT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:       if (obs_valid) state_d = S_CLEAR;
            S_CLEAR:      state_d = S_STEP;
            S_STEP:       state_d = S_WAIT_LAYER;
            S_WAIT_LAYER: begin
                if (layer_done)        state_d = S_WRITE;
                else if (wait_expired) state_d = S_IDLE;
            end
            S_WRITE:      state_d = (timestep_q == LAST_TS) ? S_Q_START : S_STEP;
            S_Q_START:    state_d = S_Q_WAIT;
            S_Q_WAIT: begin
                if (done_rise)         state_d = S_ARGMAX;
                else if (wait_expired) state_d = S_IDLE;
            end
            S_ARGMAX:     state_d = S_OUTPUT;
            S_OUTPUT:     if (result_ready) state_d = S_IDLE;
            default:      state_d = S_IDLE;
        endcase
    end

    always_comb begin
        obs_ready    = (state_q == S_IDLE);
        net_clear    = (state_q == S_CLEAR);
        layer_step   = (state_q == S_STEP);
        buf_wr_en    = (state_q == S_WRITE);
        qacc_start   = (state_q == S_Q_START);
        result_valid = (state_q == S_OUTPUT);
        busy         = (state_q != S_IDLE);
        state_dbg    = state_q;
    end

    // Signed argmax; strict compare keeps the lowest index on ties.
    always_comb begin
        best_idx = '0;
        best_val = q_values[0];
        for (int i = 1; i < NUM_ACTIONS; i++) begin
            if ($signed(q_values[i]) > $signed(best_val)) begin
                best_idx = ACT_W'(i);
                best_val = q_values[i];
            end
        end
    end

    always_comb begin
        timestep_d  = timestep_q;
        wait_cnt_d  = wait_cnt_q;
        cycles_d    = cycles_q;
        action_d    = action_q;
        q_best_d    = q_best_q;
        error_d     = error_q;
        done_prev_d = qacc_done;

        if (accept) begin
            cycles_d = '0;
            error_d  = 1'b0;
        end

        // Count every cycle from CLEAR through ARGMAX, saturating.
        if (state_q != S_IDLE && state_q != S_OUTPUT && cycles_q != '1) begin
            cycles_d = cycles_q + CYC_WIDTH'(1);
        end

        case (state_q)
            S_CLEAR:   timestep_d = '0;
            S_STEP:    wait_cnt_d = '0;
            S_Q_START: wait_cnt_d = '0;
            S_WAIT_LAYER: begin
                wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                if (!layer_done && wait_expired) error_d = 1'b1;
            end
            S_Q_WAIT: begin
                wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                if (!done_rise && wait_expired) error_d = 1'b1;
            end
            S_WRITE: begin
                if (timestep_q != LAST_TS) timestep_d = timestep_q + TS_W'(1);
            end
            S_ARGMAX: begin
                action_d = best_idx;
                q_best_d = best_val;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            timestep_q  <= '0;
            wait_cnt_q  <= '0;
            cycles_q    <= '0;
            action_q    <= '0;
            q_best_q    <= '0;
            error_q     <= 1'b0;
            done_prev_q <= 1'b0;
        end else begin
            timestep_q  <= timestep_d;
            wait_cnt_q  <= wait_cnt_d;
            cycles_q    <= cycles_d;
            action_q    <= action_d;
            q_best_q    <= q_best_d;
            error_q     <= error_d;
            done_prev_q <= done_prev_d;
        end
    end

    assign timestep = timestep_q;
    assign action   = action_q;
    assign q_best   = q_best_q;
    assign cycles   = cycles_q;
    assign error    = error_q;

endmodule

// File: tb/tb_snn_inference_sequencer.sv
// Directed bench for snn_inference_sequencer with small timestep count and timeout.
module tb_snn_inference_sequencer;

  localparam int NT  = 4;
  localparam int NA  = 2;
  localparam int DW  = 16;
  localparam int TO  = 8;
  localparam int CW  = 16;
  // CLEAR + NT*(1+2) + Q_START + 6 wait cycles + ARGMAX
  localparam int EXP_CYC = 1 + NT * 3 + 1 + 6 + 1;

  logic                  clk;
  logic                  reset;
  logic                  obs_valid;
  logic                  obs_ready;
  logic                  net_clear;
  logic                  layer_step;
  logic                  layer_done;
  logic [1:0]            timestep;
  logic                  buf_wr_en;
  logic                  qacc_start;
  logic                  qacc_done;
  logic [NA-1:0][DW-1:0] q_values;
  logic                  result_valid;
  logic                  result_ready;
  logic [0:0]            action;
  logic [DW-1:0]         q_best;
  logic [CW-1:0]         cycles;
  logic                  busy;
  logic                  error;
  logic [3:0]            state_dbg;

  int n_checks = 0;
  int n_errors = 0;

  snn_inference_sequencer #(
    .NUM_TIMESTEPS(NT), .NUM_ACTIONS(NA), .DATA_WIDTH(DW),
    .TIMEOUT_CYCLES(TO), .CYC_WIDTH(CW)
  ) dut (
    .clk(clk), .reset(reset), .obs_valid(obs_valid), .obs_ready(obs_ready),
    .net_clear(net_clear), .layer_step(layer_step), .layer_done(layer_done),
    .timestep(timestep), .buf_wr_en(buf_wr_en), .qacc_start(qacc_start),
    .qacc_done(qacc_done), .q_values(q_values), .result_valid(result_valid),
    .result_ready(result_ready), .action(action), .q_best(q_best),
    .cycles(cycles), .busy(busy), .error(error), .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives one inference from IDLE, acting as host, hidden layers (done one cycle
  // after each step) and Q accumulator. q_lat==0: done never rises. abort_ts>=0:
  // assert reset during WAIT_LAYER of that timestep and return.
  task automatic run_inf(input logic [DW-1:0] q0, input logic [DW-1:0] q1,
                         input int q_lat, input int drop_after, input bit no_layer,
                         input int abort_ts,
                         output int n_clear, output int n_step, output int n_wr,
                         output int n_qs, output int n_busy, output bit got_valid);
    bit prev_step = 1'b0;
    bit abort_next = 1'b0;
    bit finished = 1'b0;
    int qcnt = 0;
    int hold = 0;
    n_clear = 0; n_step = 0; n_wr = 0; n_qs = 0; n_busy = 0; got_valid = 1'b0;
    q_values[0] = q0;
    q_values[1] = q1;
    obs_valid = 1'b1;
    for (int k = 0; k < 300 && !finished; k++) begin
      @(negedge clk);
      obs_valid = 1'b0;
      if (k == 0) chk("err_clear_on_accept", error, 0);
      if (abort_next) begin
        layer_done = 1'b0;
        reset = 1'b1;
        finished = 1'b1;
      end else begin
        layer_done = (!no_layer && prev_step);
        prev_step = layer_step;
        if (net_clear) n_clear++;
        if (layer_step) begin
          chk("step_timestep", timestep, n_step);
          if (abort_ts >= 0 && n_step == abort_ts) abort_next = 1'b1;
          n_step++;
        end
        if (buf_wr_en) begin
          chk("wr_timestep", timestep, n_wr);
          n_wr++;
        end
        if (qacc_start) begin
          n_qs++;
          qcnt = q_lat;
          hold = drop_after;
          if (hold == 0) qacc_done = 1'b0;
        end else begin
          if (hold > 0) begin
            hold--;
            if (hold == 0) qacc_done = 1'b0;
          end
          if (qcnt > 0) begin
            qcnt--;
            if (qcnt == 0) qacc_done = 1'b1;
          end
        end
        if (busy) n_busy++;
        if (result_valid) begin
          got_valid = 1'b1;
          finished = 1'b1;
        end else if (!busy) begin
          finished = 1'b1;
        end
      end
    end
    if (!finished) begin
      n_checks++;
      n_errors++;
      $error("FAIL run_bound: observed no completion within 300 cycles expected completion");
    end
  endtask

  task automatic take_result();
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
    chk("ret_idle_obs_ready", obs_ready, 1);
    chk("ret_idle_result_valid", result_valid, 0);
  endtask

  task automatic check_good(input string tag, input int n_clear, input int n_step,
                            input int n_wr, input int n_qs, input bit got_valid,
                            input logic [0:0] exp_act, input logic [DW-1:0] exp_q);
    chk({tag, "_clear_pulses"}, n_clear, 1);
    chk({tag, "_step_pulses"}, n_step, NT);
    chk({tag, "_wr_pulses"}, n_wr, NT);
    chk({tag, "_qstart_pulses"}, n_qs, 1);
    chk({tag, "_result_valid"}, got_valid, 1);
    chk({tag, "_action"}, action, exp_act);
    chk({tag, "_q_best"}, q_best, exp_q);
    chk({tag, "_cycles"}, cycles, EXP_CYC);
    chk({tag, "_error"}, error, 0);
  endtask

  initial begin
    int nc, ns, nw, nq, nb;
    bit gv;
    logic [0:0]    hold_act;
    logic [DW-1:0] hold_q;
    logic [CW-1:0] hold_cyc;

    reset = 1'b1; obs_valid = 1'b0; layer_done = 1'b0; qacc_done = 1'b0;
    result_ready = 1'b0; q_values = '0;
    repeat (3) @(negedge clk);
    chk("rst_obs_ready", obs_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_error", error, 0);
    chk("rst_result_valid", result_valid, 0);
    chk("rst_pulses", {net_clear, layer_step, buf_wr_en, qacc_start}, 0);
    chk("rst_timestep", timestep, 0);
    chk("rst_action", action, 0);
    chk("rst_q_best", q_best, 0);
    chk("rst_cycles", cycles, 0);
    chk("rst_state", state_dbg, 0);
    reset = 1'b0;
    @(negedge clk);

    // basic inference, latency and pulse counts
    run_inf(16'h1000, 16'h0800, 6, 0, 1'b0, -1, nc, ns, nw, nq, nb, gv);
    check_good("t1", nc, ns, nw, nq, gv, 1'b0, 16'h1000);
    chk("t1_busy_cycles", nb, EXP_CYC + 1);
    take_result();

    // signed compare (qacc_done is now stale-high from the last run)
    run_inf(16'hF000, 16'h0001, 6, 0, 1'b0, -1, nc, ns, nw, nq, nb, gv);
    check_good("t2_signed", nc, ns, nw, nq, gv, 1'b1, 16'h0001);
    take_result();

    // tie goes to the lowest index
    run_inf(16'h0400, 16'h0400, 6, 0, 1'b0, -1, nc, ns, nw, nq, nb, gv);
    check_good("t2_tie", nc, ns, nw, nq, gv, 1'b0, 16'h0400);
    take_result();

    // done stays high for a few Q_WAIT cycles: only the later rise may complete
    run_inf(16'h8000, 16'h8001, 6, 3, 1'b0, -1, nc, ns, nw, nq, nb, gv);
    check_good("t3_stale", nc, ns, nw, nq, gv, 1'b1, 16'h8001);
    take_result();

    // layer_done never arrives: CLEAR + STEP + TO wait cycles, then IDLE with error
    run_inf(16'h0000, 16'h0000, 6, 0, 1'b1, -1, nc, ns, nw, nq, nb, gv);
    chk("t4_busy_cycles", nb, 2 + TO);
    chk("t4_no_valid", gv, 0);
    chk("t4_error", error, 1);
    chk("t4_obs_ready", obs_ready, 1);
    chk("t4_wr_pulses", nw, 0);

    // accumulator never finishes: Q_WAIT timeout
    run_inf(16'h0000, 16'h0000, 0, 0, 1'b0, -1, nc, ns, nw, nq, nb, gv);
    chk("t4q_busy_cycles", nb, 1 + NT * 3 + 1 + TO);
    chk("t4q_no_valid", gv, 0);
    chk("t4q_error", error, 1);
    chk("t4q_qstart_pulses", nq, 1);

    // result held in OUTPUT while host stalls; obs_valid meanwhile is ignored
    run_inf(16'h2000, 16'h7FFF, 6, 0, 1'b0, -1, nc, ns, nw, nq, nb, gv);
    check_good("t5", nc, ns, nw, nq, gv, 1'b1, 16'h7FFF);
    hold_act = action;
    hold_q   = q_best;
    hold_cyc = cycles;
    q_values[0] = 16'h7FFF;
    q_values[1] = 16'h0000;
    for (int i = 0; i < 10; i++) begin
      obs_valid = (i == 3);
      @(negedge clk);
      chk("t5_hold_valid", result_valid, 1);
      chk("t5_hold_obs_ready", obs_ready, 0);
      chk("t5_hold_action", action, 1'b1);
      chk("t5_hold_q_best", q_best, 16'h7FFF);
      chk("t5_hold_cycles", cycles, EXP_CYC);
    end
    obs_valid = 1'b0;
    take_result();
    @(negedge clk);
    chk("t5_obs_not_accepted", busy, 0);
    chk("t5_kept_action", action, hold_act);
    chk("t5_kept_q_best", q_best, hold_q);
    chk("t5_kept_cycles", cycles, hold_cyc);

    // reset during WAIT_LAYER at timestep 2
    run_inf(16'h1111, 16'h2222, 6, 0, 1'b0, 2, nc, ns, nw, nq, nb, gv);
    chk("t6_steps_before_abort", ns, 3);
    @(negedge clk);
    reset = 1'b0;
    chk("t6_state_idle", state_dbg, 0);
    chk("t6_obs_ready", obs_ready, 1);
    chk("t6_timestep", timestep, 0);
    chk("t6_pulses", {net_clear, layer_step, buf_wr_en, qacc_start}, 0);
    chk("t6_busy", busy, 0);
    chk("t6_result_valid", result_valid, 0);
    chk("t6_q_best", q_best, 0);
    @(negedge clk);
    chk("t6_no_pulse_after", {net_clear, layer_step, buf_wr_en, qacc_start}, 0);
    run_inf(16'h0123, 16'h0122, 6, 0, 1'b0, -1, nc, ns, nw, nq, nb, gv);
    check_good("t6_fresh", nc, ns, nw, nq, gv, 1'b0, 16'h0123);
    take_result();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
